// File: rtl/mem_lsu_stage.sv
// Memory-access pipeline stage between EX and WB: valid/ready on both sides, one outstanding
// data-SRAM request, sub-word byte enables / lane replication / load extension, flush drain.
module mem_lsu_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 32,
    parameter int unsigned RFW = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [AW-1:0]    ex_pc,
    input  logic [3:0]       ex_op,
    input  logic [AW-1:0]    ex_addr,
    input  logic [DW-1:0]    ex_wdata,
    input  logic             ex_rf_we,
    input  logic [RFW-1:0]   ex_rf_waddr,
    input  logic             ex_hi_we,
    input  logic             ex_lo_we,
    input  logic [DW-1:0]    ex_hi,
    input  logic [DW-1:0]    ex_lo,
    output logic             req_valid,
    output logic             req_wr,
    output logic [AW-1:0]    req_addr,
    output logic [DW/8-1:0]  req_be,
    output logic [DW-1:0]    req_wdata,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [DW-1:0]    rsp_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [AW-1:0]    wb_pc,
    output logic             wb_rf_we,
    output logic [RFW-1:0]   wb_rf_waddr,
    output logic [DW-1:0]    wb_rf_wdata,
    output logic             wb_hi_we,
    output logic             wb_lo_we,
    output logic [DW-1:0]    wb_hi,
    output logic [DW-1:0]    wb_lo,
    output logic             wb_excp,
    output logic             fwd_we,
    output logic [RFW-1:0]   fwd_waddr,
    output logic [DW-1:0]    fwd_wdata,
    output logic             fwd_pending
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned OB = $clog2(NB);
    localparam int unsigned IW = $clog2(DW);

    localparam logic [OB-1:0] OFF_WMASK  = ~OB'(3);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(NB - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           ld_q, ld_d;
    logic           sgn_q, sgn_d;
    logic [1:0]     sz_q, sz_d;
    logic           wr_q, wr_d;
    logic [NB-1:0]  be_q, be_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           rf_we_q, rf_we_d;
    logic [RFW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]  rf_wdata_q, rf_wdata_d;
    logic           hi_we_q, hi_we_d;
    logic           lo_we_q, lo_we_d;
    logic [DW-1:0]  hi_q, hi_d;
    logic [DW-1:0]  lo_q, lo_d;
    logic           excp_q, excp_d;

    // Access-type decode; 64-bit codes collapse to NONE on a 32-bit datapath
    logic       ex_ld, ex_st, ex_sgn, ex_mis;
    logic [1:0] ex_sz;
    always_comb begin
        ex_ld  = 1'b0;
        ex_st  = 1'b0;
        ex_sgn = 1'b0;
        ex_sz  = 2'd0;
        case (ex_op)
            4'd1:  begin ex_ld = 1'b1; ex_sgn = 1'b1; ex_sz = 2'd0; end
            4'd2:  begin ex_ld = 1'b1; ex_sz = 2'd0; end
            4'd3:  begin ex_ld = 1'b1; ex_sgn = 1'b1; ex_sz = 2'd1; end
            4'd4:  begin ex_ld = 1'b1; ex_sz = 2'd1; end
            4'd5:  begin ex_ld = 1'b1; ex_sgn = 1'b1; ex_sz = 2'd2; end
            4'd6:  begin ex_st = 1'b1; ex_sz = 2'd0; end
            4'd7:  begin ex_st = 1'b1; ex_sz = 2'd1; end
            4'd8:  begin ex_st = 1'b1; ex_sz = 2'd2; end
            4'd9:  if (DW == 64) begin ex_ld = 1'b1; ex_sz = 2'd2; end
            4'd10: if (DW == 64) begin ex_ld = 1'b1; ex_sz = 2'd3; end
            4'd11: if (DW == 64) begin ex_st = 1'b1; ex_sz = 2'd3; end
            default: ;
        endcase
    end

    // Misalignment, byte enables and lane replication for the incoming access
    logic [OB-1:0] ex_off;
    logic [NB-1:0] ex_be;
    logic [DW-1:0] ex_wrep;
    always_comb begin
        ex_off  = ex_addr[OB-1:0];
        ex_mis  = 1'b0;
        ex_be   = '1;
        ex_wrep = ex_wdata;
        case (ex_sz)
            2'd0: begin
                ex_be   = NB'(1) << ex_off;
                ex_wrep = {NB{ex_wdata[7:0]}};
            end
            2'd1: begin
                ex_mis  = ex_addr[0];
                ex_be   = NB'(3) << ex_off;
                ex_wrep = {(NB/2){ex_wdata[15:0]}};
            end
            2'd2: begin
                ex_mis  = |ex_addr[1:0];
                ex_be   = NB'(4'hF) << (ex_off & OFF_WMASK);
                ex_wrep = {(NB/4){ex_wdata[31:0]}};
            end
            default: ex_mis = |ex_addr[2:0];
        endcase
        if (!(ex_ld || ex_st)) ex_mis = 1'b0;
    end

    // Load lane select and sign/zero extension of the response
    logic [OB-1:0] ld_off;
    logic [DW-1:0] ld_shift, ld_mask, ld_data;
    logic [IW-1:0] ld_msb;
    always_comb begin
        ld_off   = addr_q[OB-1:0];
        ld_shift = rsp_rdata >> {ld_off, 3'b000};
        case (sz_q)
            2'd0:    begin ld_mask = DW'(8'hFF);         ld_msb = IW'(7);  end
            2'd1:    begin ld_mask = DW'(16'hFFFF);      ld_msb = IW'(15); end
            2'd2:    begin ld_mask = DW'(32'hFFFF_FFFF); ld_msb = IW'(31); end
            default: begin ld_mask = '1;                 ld_msb = IW'(DW - 1); end
        endcase
        ld_data = (ld_shift & ld_mask) | ((sgn_q && ld_shift[ld_msb]) ? ~ld_mask : '0);
    end

    logic accept;
    assign ex_ready = ((state_q == S_IDLE) || ((state_q == S_DONE) && wb_ready)) && !flush;
    assign accept   = ex_valid && ex_ready;

    // Next-state and payload update; flush outranks every other event
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ld_d       = ld_q;
        sgn_d      = sgn_q;
        sz_d       = sz_q;
        wr_d       = wr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        hi_we_d    = hi_we_q;
        lo_we_d    = lo_we_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        excp_d     = excp_q;
        case (state_q)
            S_IDLE: ;
            S_REQ: begin
                if (flush)          state_d = req_ready ? S_DRAIN : S_IDLE;
                else if (req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = rsp_valid ? S_IDLE : S_DRAIN;
                end else if (rsp_valid) begin
                    state_d = S_DONE;
                    if (ld_q) rf_wdata_d = ld_data;
                end
            end
            S_DONE:  if (flush || wb_ready) state_d = S_IDLE;
            S_DRAIN: if (rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d    = (ex_mis || !(ex_ld || ex_st)) ? S_DONE : S_REQ;
            pc_d       = ex_pc;
            addr_d     = ex_addr;
            ld_d       = ex_ld && !ex_mis;
            sgn_d      = ex_sgn;
            sz_d       = ex_sz;
            wr_d       = ex_st;
            be_d       = ex_be;
            wdata_d    = ex_wrep;
            rf_we_d    = ex_rf_we && !ex_mis && !ex_st;
            rf_waddr_d = ex_rf_waddr;
            rf_wdata_d = (ex_ld || ex_st) ? '0 : DW'(ex_addr);
            hi_we_d    = ex_hi_we;
            lo_we_d    = ex_lo_we;
            hi_d       = ex_hi;
            lo_d       = ex_lo;
            excp_d     = ex_mis;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            ld_q       <= 1'b0;
            sgn_q      <= 1'b0;
            sz_q       <= 2'd0;
            wr_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            excp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ld_q       <= ld_d;
            sgn_q      <= sgn_d;
            sz_q       <= sz_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            hi_we_q    <= hi_we_d;
            lo_we_q    <= lo_we_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            excp_q     <= excp_d;
        end
    end

    logic busy;
    assign busy = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DONE);

    assign req_valid   = (state_q == S_REQ);
    assign req_wr      = wr_q;
    assign req_addr    = addr_q & ALIGN_MASK;
    assign req_be      = be_q;
    assign req_wdata   = wdata_q;
    assign wb_valid    = (state_q == S_DONE);
    assign wb_pc       = pc_q;
    assign wb_rf_we    = rf_we_q;
    assign wb_rf_waddr = rf_waddr_q;
    assign wb_rf_wdata = rf_wdata_q;
    assign wb_hi_we    = hi_we_q;
    assign wb_lo_we    = lo_we_q;
    assign wb_hi       = hi_q;
    assign wb_lo       = lo_q;
    assign wb_excp     = excp_q;
    assign fwd_we      = busy && rf_we_q && !excp_q;
    assign fwd_waddr   = rf_waddr_q;
    assign fwd_wdata   = rf_wdata_q;
    assign fwd_pending = ld_q && ((state_q == S_REQ) || (state_q == S_WAIT));

endmodule
